chunked_dot_consumer: RTL and testbench



---
 rtl/chunked_dot_consumer.sv | 155 +++++++++++++++
 tb/tb_chunked_dot_consumer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_dot_consumer.sv
// Purpose: consumes (x, y) pairs, accumulates x*y and emits one (sum, count) tuple per chunk, flushing a partial chunk on upstream done.
// Latency: a tuple is valid the cycle after the handshake that completes its chunk; _done follows upstream done through FLUSH and DRAIN.
// Backpressure: _in_ready drops while an output tuple is held and _ready is low, so upstream stalls without losing or duplicating data.
//
// Ports:
//   _clock, _reset      clock and asynchronous active-high reset
//   chunk, _start       pairs per tuple (<= 0 treated as 1), captured on the one-cycle _start pulse
//   _ready/_valid       downstream handshake for (_out0 = signed sum, _out1 = pair count)
//   _done               one-cycle pulse once all output has been delivered
//   _in0/_in1           upstream x / y, qualified by _in_valid, accepted when _in_ready
//   _in_done            upstream done pulse, only acted on while accumulating
module chunked_dot_consumer #(
    parameter int WIDTH = 32
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic [WIDTH-1:0] chunk,
    input  logic             _start,
    input  logic             _ready,
    output logic             _valid,
    output logic             _done,
    output logic [WIDTH-1:0] _out0,
    output logic [WIDTH-1:0] _out1,
    input  logic [WIDTH-1:0] _in0,
    input  logic [WIDTH-1:0] _in1,
    input  logic             _in_valid,
    input  logic             _in_done,
    output logic             _in_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] out0_q, out0_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] chunk_q, chunk_d;

    logic             in_hs;
    logic [WIDTH-1:0] prod;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] cnt_next;

    // A new pair may enter whenever the output slot is free or is being
    // emptied this cycle, which keeps one pair per cycle with no bubbles.
    assign _in_ready = (state_q == ACCUM) && !_start && (!valid_q || _ready);
    assign in_hs     = _in_valid && _in_ready;

    // The low WIDTH bits of a two's complement product are the same whether
    // the operands are read as signed or unsigned, so a plain multiply works.
    assign prod     = _in0 * _in1;
    assign sum_next = acc_q + prod;
    assign cnt_next = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q && !_ready;
        done_d  = 1'b0;
        out0_d  = out0_q;
        out1_d  = out1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        chunk_d = chunk_q;

        if (_start) begin
            // Zero or negative chunk sizes degrade to one pair per tuple.
            chunk_d = (chunk[WIDTH-1] || (chunk == '0)) ? ONE : chunk;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        if (cnt_next == chunk_q) begin
                            out0_d  = sum_next;
                            out1_d  = cnt_next;
                            valid_d = 1'b1;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            acc_d = sum_next;
                            cnt_d = cnt_next;
                        end
                    end
                    if (_in_done) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    // A chunk that completed alongside done leaves cnt at
                    // zero, so no empty tuple is produced.
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                    end else if (!valid_q || _ready) begin
                        out0_d  = acc_q;
                        out1_d  = cnt_q;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    // Wait until the last tuple has left before reporting done.
                    if (!valid_q && _ready) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            out0_q  <= '0;
            out1_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            chunk_q <= ONE;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            chunk_q <= chunk_d;
        end
    end

    assign _valid = valid_q;
    assign _done  = done_q;
    assign _out0  = out0_q;
    assign _out1  = out1_q;

endmodule

// File: tb/tb_chunked_dot_consumer.sv
// Purpose: directed bench for chunked_dot_consumer with a queue-based scoreboard.
// Latency: expected tuples and done markers are queued by stimulus and popped by an independent monitor.
// Backpressure: a selectable 1,0,0,1 _ready pattern exercises tuple holding and upstream stalls.
module tb_chunked_dot_consumer;

    localparam int WIDTH = 32;

    logic             _clock;
    logic             _reset;
    logic [WIDTH-1:0] chunk;
    logic             _start;
    logic             _ready;
    logic             _valid;
    logic             _done;
    logic [WIDTH-1:0] _out0;
    logic [WIDTH-1:0] _out1;
    logic [WIDTH-1:0] _in0;
    logic [WIDTH-1:0] _in1;
    logic             _in_valid;
    logic             _in_done;
    logic             _in_ready;

    chunked_dot_consumer #(.WIDTH(WIDTH)) dut (
        ._clock   (_clock),
        ._reset   (_reset),
        .chunk    (chunk),
        ._start   (_start),
        ._ready   (_ready),
        ._valid   (_valid),
        ._done    (_done),
        ._out0    (_out0),
        ._out1    (_out1),
        ._in0     (_in0),
        ._in1     (_in1),
        ._in_valid(_in_valid),
        ._in_done (_in_done),
        ._in_ready(_in_ready)
    );

    typedef struct {
        bit               is_done;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   ready_toggle = 0;
    bit   ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   cyc = 0;

    initial begin
        _clock = 1'b0;
        forever #5 _clock = ~_clock;
    end

    // Downstream ready driver: always high, or the repeating 1,0,0,1 pattern.
    initial begin
        _ready = 1'b1;
        forever begin
            @(posedge _clock);
            #1;
            _ready = ready_toggle ? ready_pat[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    task automatic push_tuple(input int s, input int c);
        exp_t e;
        e.is_done = 1'b0;
        e.sum     = s;
        e.cnt     = c;
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.sum     = '0;
        e.cnt     = '0;
        sb.push_back(e);
    endtask

    // Monitor: inputs change just after posedge, so the negedge view is what
    // the DUT will act on at the next posedge.
    always @(negedge _clock) begin
        if (!_reset) begin
            if (_valid && !_ready) begin
                n_tests++;
                if (_in_ready) begin
                    n_fail++;
                    $display("FAIL held_stall: _in_ready=%0b while tuple held, required 0", _in_ready);
                end
            end
            if (_valid && _ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL tuple_extra: got (%0d,%0d), required nothing", $signed(_out0), $signed(_out1));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.is_done || _out0 !== e.sum || _out1 !== e.cnt) begin
                        n_fail++;
                        $display("FAIL tuple: got (%0d,%0d), required %s(%0d,%0d)", $signed(_out0), $signed(_out1),
                                 e.is_done ? "done " : "", $signed(e.sum), $signed(e.cnt));
                    end
                end
            end
            if (_done) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_extra: got _done=1, required no pulse");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (!e.is_done) begin
                        n_fail++;
                        $display("FAIL done_order: got _done, required tuple (%0d,%0d)", $signed(e.sum), $signed(e.cnt));
                    end
                end
            end
        end
    end

    task automatic do_start(input int c);
        @(posedge _clock);
        #1;
        chunk  = c;
        _start = 1'b1;
        @(posedge _clock);
        #1;
        _start = 1'b0;
    endtask

    // Presents one pair and holds it until accepted; with_done raises
    // _in_done only in the accepting cycle.
    task automatic send_pair(input int x, input int y, input bit with_done);
        int waited;
        _in0      = x;
        _in1      = y;
        _in_valid = 1'b1;
        waited    = 0;
        forever begin
            @(negedge _clock);
            if (_in_ready) break;
            waited++;
            if (waited > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL in_ready_timeout: _in_ready=0 for %0d cycles, required 1", waited);
                break;
            end
        end
        if (with_done) _in_done = 1'b1;
        @(posedge _clock);
        #1;
        _in_valid = 1'b0;
        _in_done  = 1'b0;
    endtask

    task automatic send_done();
        @(posedge _clock);
        #1;
        _in_done = 1'b1;
        @(posedge _clock);
        #1;
        _in_done = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(negedge _clock);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d expected outputs never seen, required 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge _clock);
        #1;
    endtask

    task automatic check_val(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int n;
        _reset    = 1'b1;
        chunk     = '0;
        _start    = 1'b0;
        _in0      = '0;
        _in1      = '0;
        _in_valid = 1'b0;
        _in_done  = 1'b0;
        #22;
        check_val("reset_valid", {31'd0, _valid}, 0);
        check_val("reset_done", {31'd0, _done}, 0);
        check_val("reset_out0", _out0, 0);
        check_val("reset_out1", _out1, 0);
        check_val("reset_in_ready", {31'd0, _in_ready}, 0);
        @(posedge _clock);
        #1;
        _reset = 1'b0;

        // 1: chunk=2, last chunk completes together with done
        push_tuple(1, 2);
        push_tuple(13, 2);
        push_done();
        do_start(2);
        send_pair(0, 0, 0);
        send_pair(1, 1, 0);
        send_pair(2, 2, 0);
        send_pair(3, 3, 1);
        wait_drained("t1");

        // 2: chunk=3, partial chunk flushed
        push_tuple(14, 3);
        push_tuple(16, 1);
        push_done();
        do_start(3);
        for (int i = 1; i <= 4; i++) send_pair(i, i, i == 4);
        wait_drained("t2");

        // 3: chunk=0 behaves as chunk=1, signed products
        push_tuple(-6, 1);
        push_tuple(-5, 1);
        push_done();
        do_start(0);
        send_pair(-2, 3, 0);
        send_pair(5, -1, 1);
        wait_drained("t3");

        // 4: chunk=4 with downstream backpressure
        push_tuple(14, 4);
        push_tuple(126, 4);
        push_tuple(145, 2);
        push_done();
        ready_toggle = 1'b1;
        do_start(4);
        for (int i = 0; i < 10; i++) send_pair(i, i, 0);
        send_done();
        wait_drained("t4");
        ready_toggle = 1'b0;
        repeat (2) @(posedge _clock);
        #1;

        // 5: done with zero pairs, no tuple and delayed _done
        push_done();
        do_start(3);
        @(posedge _clock);
        #1;
        _in_done = 1'b1;
        @(posedge _clock);
        #1;
        _in_done = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge _clock);
            n++;
            if (_done) break;
        end
        n_tests++;
        if (!_done || n < 2 || n > 3) begin
            n_fail++;
            $display("FAIL t5_done_latency: got _done=%0b after %0d cycles, required 1 after 2..3", _done, n);
        end
        wait_drained("t5");

        // 6: reset mid-chunk, then a clean run
        do_start(4);
        send_pair(7, 7, 0);
        send_pair(3, 5, 0);
        @(posedge _clock);
        #1;
        _reset = 1'b1;
        #1;
        check_val("t6_rst_valid", {31'd0, _valid}, 0);
        check_val("t6_rst_done", {31'd0, _done}, 0);
        check_val("t6_rst_out0", _out0, 0);
        check_val("t6_rst_out1", _out1, 0);
        check_val("t6_rst_in_ready", {31'd0, _in_ready}, 0);
        @(posedge _clock);
        #1;
        _reset = 1'b0;
        push_tuple(2, 2);
        push_done();
        do_start(2);
        send_pair(1, 1, 0);
        send_pair(1, 1, 1);
        wait_drained("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
